// File: rtl/fft_butterfly_scheduler.sv
// fft_butterfly_scheduler: issues radix-2 butterfly commands stage by stage, holding each stage until its write-backs return
//   Clock, Areset (async, active-low)            clocking and reset
//   Start, Abort                                 transform request / synchronous cancel
//   BfValid, BfReady, BfTop, BfBot, BfTw, BfStage  butterfly command handshake and fields
//   BfWb                                         one pulse per completed butterfly write-back
//   Busy, Done, Err                              status: running, completion pulse, sticky protocol error
module fft_butterfly_scheduler #(
  parameter int N = 16,
  parameter int LOGN = 4,
  localparam int SW = (LOGN > 1) ? $clog2(LOGN) : 1,
  localparam int TW = LOGN - 1
) (
  input  logic          Clock,
  input  logic          Areset,
  input  logic          Start,
  input  logic          Abort,
  output logic          BfValid,
  input  logic          BfReady,
  output logic [LOGN-1:0] BfTop,
  output logic [LOGN-1:0] BfBot,
  output logic [TW-1:0]   BfTw,
  output logic [SW-1:0]   BfStage,
  input  logic          BfWb,
  output logic          Busy,
  output logic          Done,
  output logic          Err
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam int OW = LOGN;
  localparam logic [SW-1:0] LAST_S = SW'(LOGN - 1);
  state_t state, state_d;
  logic [SW-1:0] stage, stage_d, tsh;
  logic [TW-1:0] k, k_d;
  logic [OW-1:0] outstanding, out_d;
  logic err, err_d, err_set, fire, drained;
  logic [LOGN-1:0] k_ext, half, mask, lo, top;
  logic [SW:0] s1;
  always_ff @(posedge Clock or negedge Areset)
    if (!Areset) begin
      state <= IDLE;
      stage <= '0;
      k <= '0;
      outstanding <= '0;
      err <= 1'b0;
    end else begin
      state <= state_d;
      stage <= stage_d;
      k <= k_d;
      outstanding <= out_d;
      err <= err_d;
    end
  // k splits into a block number (upper bits) and an offset j within a 2^s-wide half-block
  always_comb begin
    k_ext = {1'b0, k};
    half = LOGN'(1) << stage;
    mask = half - LOGN'(1);
    lo = k_ext & mask;
    s1 = {1'b0, stage} + (SW+1)'(1);
    tsh = LAST_S - stage;
    top = ((k_ext >> stage) << s1) | lo;
  end
  assign BfValid = state == ISSUE;
  assign fire = BfValid & BfReady;
  // fields are forced to zero while no command is offered so idle/reset outputs read as 0
  assign BfTop = BfValid ? top : '0;
  assign BfBot = BfValid ? top + half : '0;
  assign BfTw = BfValid ? TW'(lo << tsh) : '0;
  assign BfStage = BfValid ? stage : '0;
  assign Busy = (state == ISSUE) | (state == DRAIN);
  assign Done = state == DONE;
  assign Err = err;
  assign err_set = BfWb & ~fire & (outstanding == '0);
  // a write-back arriving in the same cycle as the count reaching 1 already empties the stage
  assign drained = (outstanding == '0) | ((outstanding == OW'(1)) & BfWb);
  always_comb begin
    state_d = state;
    stage_d = stage;
    k_d = k;
    out_d = (fire & ~BfWb) ? outstanding + OW'(1) : (BfWb & ~fire & ~err_set) ? outstanding - OW'(1) : outstanding;
    err_d = err | err_set;
    case (state)
      IDLE: if (Start) begin
        state_d = ISSUE;
        stage_d = '0;
        k_d = '0;
        out_d = '0;
        err_d = 1'b0;
      end
      ISSUE: if (fire) begin
        k_d = k + TW'(1);
        state_d = (k == TW'(N/2 - 1)) ? DRAIN : ISSUE;
      end
      DRAIN: if (drained) begin
        state_d = (stage == LAST_S) ? DONE : ISSUE;
        stage_d = (stage == LAST_S) ? stage : stage + SW'(1);
        k_d = '0;
      end
      default: state_d = IDLE;
    endcase
    if (Abort) begin
      state_d = IDLE;
      stage_d = '0;
      k_d = '0;
      out_d = '0;
      err_d = err | err_set;
    end
  end
endmodule

// File: tb/tb_fft_butterfly_scheduler.sv
// tb_fft_butterfly_scheduler: scoreboard bench for fft_butterfly_scheduler with a model-driven butterfly unit
module tb_fft_butterfly_scheduler;
  localparam int N = 16;
  localparam int LOGN = 4;
  localparam int CW = 2*LOGN + (LOGN-1) + 2;
  logic Clock = 1'b0;
  logic Areset, Start, Abort, BfReady, BfWb;
  logic BfValid, Busy, Done, Err;
  logic [LOGN-1:0] BfTop, BfBot;
  logic [LOGN-2:0] BfTw;
  logic [1:0] BfStage;
  int tests = 0, fails = 0, cyc = 0;
  int pending = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0, last_wb_cyc = 0;
  int lat = 3, fire_idx = 0, vis_stage = 0;
  bit rand_ready = 0, hold = 0, wb_en = 1, inj_wb = 0;
  logic [CW-1:0] exp_q[$];
  int wb_q[$];
  fft_butterfly_scheduler #(.N(N), .LOGN(LOGN)) dut (
    .Clock(Clock), .Areset(Areset), .Start(Start), .Abort(Abort),
    .BfValid(BfValid), .BfReady(BfReady), .BfTop(BfTop), .BfBot(BfBot),
    .BfTw(BfTw), .BfStage(BfStage), .BfWb(BfWb), .Busy(Busy), .Done(Done), .Err(Err)
  );
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endfunction
  // reference: radix-2 butterflies enumerated block by block, offset j inside each half-block
  function automatic void build_exp();
    exp_q.delete();
    for (int s = 0; s < LOGN; s++) begin
      int h;
      h = 1 << s;
      for (int b = 0; b < N; b += 2*h)
        for (int j = 0; j < h; j++)
          exp_q.push_back({4'(b+j), 4'(b+j+h), 3'(j*(N/(2*h))), 2'(s)});
    end
  endfunction
  // butterfly-unit model: random readiness, write-backs returned at scheduled cycles
  initial forever begin
    @(posedge Clock);
    #1;
    BfReady = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    BfWb = 1'b0;
    if (inj_wb) begin
      BfWb = 1'b1;
      inj_wb = 0;
    end else if (wb_en && wb_q.size() > 0 && wb_q[0] <= cyc) begin
      BfWb = 1'b1;
      void'(wb_q.pop_front());
    end
  end
  // monitor / scoreboard
  initial begin
    logic [CW-1:0] held, got, e;
    bit stall_hold;
    stall_hold = 0;
    held = '0;
    forever begin
      @(negedge Clock);
      if (!Areset) stall_hold = 0;
      else begin
        got = {BfTop, BfBot, BfTw, BfStage};
        if (stall_hold) begin
          chk("stall_valid", BfValid, 1);
          chk("stall_fields", got, held);
        end
        stall_hold = BfValid && !BfReady && !Abort;
        held = got;
        if (BfWb) begin
          pending--;
          last_wb_cyc = cyc;
        end
        if (BfValid && int'(BfStage) != vis_stage) begin
          chk("hazard_pending", pending, 0);
          chk("stage_gap", cyc, last_wb_cyc + 1);
          vis_stage = int'(BfStage);
        end
        if (BfValid && BfReady && !Abort) begin
          chk("cmd_avail", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cmd", got, e);
          end
          pending++;
          wb_q.push_back(cyc + lat + ((hold && fire_idx == N/2 - 1) ? 20 : 0));
          fire_idx++;
        end
        if (Done) begin
          done_cnt++;
          done_cyc = cyc;
          chk("done_exp_empty", exp_q.size(), 0);
          chk("done_pending", pending, 0);
          chk("done_busy", Busy, 0);
        end
      end
    end
  end
  task automatic start_pulse();
    @(posedge Clock);
    #2;
    Start = 1'b1;
    start_cyc = cyc;
    @(posedge Clock);
    #2;
    Start = 1'b0;
  endtask
  task automatic run(input int l, input bit r, input bit h);
    int d0;
    d0 = done_cnt;
    lat = l;
    rand_ready = r;
    hold = h;
    fire_idx = 0;
    vis_stage = 0;
    build_exp();
    start_pulse();
    chk("start_err_clr", Err, 0);
    chk("start_busy", Busy, 1);
    if (r) begin
      repeat (5) @(posedge Clock);
      #2;
      Start = 1'b1;
      @(posedge Clock);
      #2;
      Start = 1'b0;
    end
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(posedge Clock);
    chk("done_seen", done_cnt, d0 + 1);
    if (!r && !h) chk("latency_bound", (done_cyc - start_cyc) <= LOGN*(N/2 + l + 1) + 2, 1);
    repeat (4) @(posedge Clock);
    #2;
    chk("single_done", done_cnt, d0 + 1);
    chk("end_busy", Busy, 0);
    chk("end_err", Err, 0);
  endtask
  initial begin
    int d0;
    Areset = 1'b0;
    Start = 1'b0;
    Abort = 1'b0;
    BfReady = 1'b1;
    BfWb = 1'b0;
    repeat (3) @(posedge Clock);
    #2;
    chk("rst_outputs", {BfValid, BfTop, BfBot, BfTw, BfStage, Busy, Done, Err}, 0);
    @(negedge Clock);
    #1;
    Areset = 1'b1;
    repeat (2) @(posedge Clock);
    #2;
    chk("idle_outputs", {BfValid, BfTop, BfBot, BfTw, BfStage, Busy, Done, Err}, 0);
    run(3, 0, 0);
    run($urandom_range(1, 4), 1, 0);
    run(2, 0, 1);
    // abort during stage 2
    lat = 1;
    rand_ready = 1;
    hold = 0;
    fire_idx = 0;
    vis_stage = 0;
    build_exp();
    d0 = done_cnt;
    start_pulse();
    for (int i = 0; i < 1000 && !(BfValid && BfStage == 2'd2); i++) begin
      @(posedge Clock);
      #2;
    end
    chk("abort_reach_s2", BfStage, 2);
    Abort = 1'b1;
    wb_en = 0;
    wb_q.delete();
    @(posedge Clock);
    #2;
    Abort = 1'b0;
    pending = 0;
    exp_q.delete();
    chk("abort_valid", BfValid, 0);
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    repeat (10) @(posedge Clock);
    #2;
    chk("abort_no_done", done_cnt, d0);
    chk("abort_err", Err, 0);
    wb_en = 1;
    run(1, 0, 0);
    // stray write-back while idle
    inj_wb = 1;
    repeat (3) @(posedge Clock);
    #2;
    chk("err_set", Err, 1);
    repeat (5) @(posedge Clock);
    #2;
    chk("err_sticky", Err, 1);
    chk("err_idle_busy", Busy, 0);
    pending = 0;
    run(3, 0, 0);
    // reset asserted while draining
    lat = 3;
    rand_ready = 0;
    hold = 0;
    fire_idx = 0;
    vis_stage = 0;
    build_exp();
    d0 = done_cnt;
    start_pulse();
    for (int i = 0; i < 1000 && !(Busy && !BfValid); i++) begin
      @(posedge Clock);
      #2;
    end
    chk("drain_reached", Busy && !BfValid, 1);
    #2;
    Areset = 1'b0;
    wb_en = 0;
    #1;
    chk("async_rst_outputs", {BfValid, BfTop, BfBot, BfTw, BfStage, Busy, Done, Err}, 0);
    wb_q.delete();
    exp_q.delete();
    pending = 0;
    repeat (3) @(negedge Clock);
    #1;
    Areset = 1'b1;
    wb_en = 1;
    repeat (3) @(posedge Clock);
    #2;
    chk("rst_no_done", done_cnt, d0);
    chk("rst_idle_busy", Busy, 0);
    run(3, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fft_butterfly_scheduler.md
FFT_BUTTERFLY_SCHEDULER -- requirements
Module: fft_butterfly_scheduler

Interface
REQ-001 Parameter N, default 16: transform length; power of two.
REQ-002 Parameter LOGN, default 4: log2(N); number of stages.
REQ-003 Clock  input  1  sole clock; all state updates on posedge.
REQ-004 Areset  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  request a full N-point transform; sampled only in IDLE.
REQ-006 Abort  input  1  synchronous cancel; return to IDLE next cycle.
REQ-007 BfValid  output  1  butterfly command valid.
REQ-008 BfReady  input  1  butterfly unit accepts command.
REQ-009 BfTop  output  LOGN  top operand index.
REQ-010 BfBot  output  LOGN  bottom operand index.
REQ-011 BfTw  output  LOGN-1  twiddle index into the N/2-entry W table.
REQ-012 BfStage  output  clog2(LOGN)  current stage number.
REQ-013 BfWb  input  1  one pulse per completed butterfly write-back.
REQ-014 Busy  output  1  high in ISSUE or DRAIN.
REQ-015 Done  output  1  one-cycle pulse on transform completion.
REQ-016 Err  output  1  sticky protocol-error flag.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, DRAIN, DONE; encoding is free.
REQ-018 IDLE: Start=1 -> ISSUE with stage=0, k=0, outstanding=0, Err cleared; otherwise stay.
REQ-019 ISSUE: BfValid=1; fire = BfValid & BfReady; each fire increments k (0..N/2-1) and outstanding.
REQ-020 Command for stage s, index k: half=2^s; top=((k>>s)<<(s+1)) + (k & (half-1)); bot=top+half; tw=(k & (half-1))<<(LOGN-1-s); all combinational from registered s,k.
REQ-021 BfTop/BfBot/BfTw/BfStage SHALL hold stable while BfValid=1 and BfReady=0.
REQ-022 Fire with k=N/2-1 -> DRAIN; BfValid=0 in DRAIN.
REQ-023 BfWb decrements outstanding; simultaneous fire and BfWb leave outstanding unchanged.
REQ-024 Outstanding counter SHALL be clog2(N/2)+1 bits, never exceeding N/2.
REQ-025 DRAIN: when outstanding reaches 0 (counting a same-cycle BfWb), s<LOGN-1 -> ISSUE next cycle with s+1, k=0; s=LOGN-1 -> DONE.
REQ-026 No command of stage s+1 SHALL issue before all write-backs of stage s return (inter-stage hazard).
REQ-027 DONE: Done=1 for exactly one cycle, then IDLE.
REQ-028 BfWb while outstanding=0 (including in IDLE/DONE): set Err, counter stays 0.
REQ-029 Start outside IDLE SHALL be ignored; Start in the DONE cycle not accepted.
REQ-030 Abort in any state -> IDLE next cycle, k, s, outstanding cleared, BfValid=0, no Done; Abort beats Start; Err retained.
REQ-031 Minimum transform latency with BfReady=1 and 1-cycle write-back: Start to Done pulse bounded by LOGN*(N/2+L+1)+2 cycles, L = butterfly latency.

Reset
REQ-032 Areset=0 SHALL immediately force IDLE, s=0, k=0, outstanding=0.
REQ-033 Reset values: BfValid=0, BfTop=0, BfBot=0, BfTw=0, BfStage=0, Busy=0, Done=0, Err=0.
REQ-034 Reset asserted mid-transform SHALL abandon it with no Done pulse; Start required afterwards.

Verification
REQ-035 BfReady=1, BfWb 3 cycles after each fire, N=16: 32 commands; stage0 (0,1,0),(2,3,0)..; stage1 (0,2,0),(1,3,4),(4,6,0); stage3 (0,8,0),(1,9,1)..(7,15,7); single Done pulse.
REQ-036 Random BfReady stalls: fields stable across stall cycles, command sequence identical to REQ-035.
REQ-037 Withhold last stage-0 BfWb 20 cycles: no stage-1 BfValid until it arrives; stage 1 issues the cycle after.
REQ-038 Abort during stage 2 issue -> IDLE next cycle, Busy=0, no Done; later Start reruns from (0,1,0).
REQ-039 BfWb pulse in IDLE -> Err=1, held until next accepted Start clears it.
REQ-040 Areset low mid-DRAIN -> all outputs 0 asynchronously; Start after release runs full 32-command sequence.
